// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end for the combinational ALU.
// Commands are buffered in a DEPTH-entry FIFO and issued one at a time
// on registered operand lines. Each command takes an IDLE -> EXEC slot.
// The ALU result and flags are captured into a response register that is
// drained through a valid/ready handshake.
// Optional feature: define ALU_SEQ_ILLEGAL_TRAP_EN to trap opcode 3'b101.
// A trapped command still takes its slot but never raises alu_valid_data.
// It returns data 0, carry 0, zero 1, the ALU slt flag and rsp_error 1.
module alu_op_sequencer #(
    parameter int WIDTH  = 8,
    parameter int OPCODE = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    // command side
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_data_in1,
    input  logic [WIDTH-1:0]         cmd_data_in2,
    input  logic [OPCODE-1:0]        cmd_op_code,
    output logic [$clog2(DEPTH):0]   cmd_level,
    // ALU side
    output logic [WIDTH-1:0]         alu_data_in1,
    output logic [WIDTH-1:0]         alu_data_in2,
    output logic [OPCODE-1:0]        alu_op_code,
    output logic                     alu_valid_data,
    input  logic [WIDTH-1:0]         alu_data_out,
    input  logic                     alu_carry_out,
    input  logic                     alu_zero_flag,
    input  logic                     alu_slt_flag,
    // response side
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_carry,
    output logic                     rsp_zero,
    output logic                     rsp_slt,
    output logic                     rsp_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam logic [OPCODE-1:0] ILLEGAL_OP = OPCODE'(3'b101);
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [OPCODE-1:0] op;
        logic [WIDTH-1:0]  in2;
        logic [WIDTH-1:0]  in1;
    } cmd_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,    state_d;
    cmd_t               fifo_mem_q [DEPTH];
    cmd_t               fifo_mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0]      count_q,    count_d;

    logic [WIDTH-1:0]   alu_in1_q,  alu_in1_d;
    logic [WIDTH-1:0]   alu_in2_q,  alu_in2_d;
    logic [OPCODE-1:0]  alu_op_q,   alu_op_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q,  rsp_data_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_zero_q,  rsp_zero_d;
    logic               rsp_slt_q,   rsp_slt_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic               rsp_error_q, rsp_error_d;
    logic               exec_illegal;
`endif

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic issue;
    logic capture;
    cmd_t cmd_in;
    cmd_t head;

    assign fifo_full  = (count_q == LW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // cmd_ready depends on registered occupancy only, so a full FIFO
    // refuses a push even if the head is popped on the same edge.
    assign push    = cmd_valid && !fifo_full;
    // Issue only when the response slot will be free by the capture edge.
    assign issue   = (state_q == S_IDLE) && !fifo_empty && (!rsp_valid_q || rsp_ready);
    assign capture = (state_q == S_EXEC);

    assign cmd_in = '{op: cmd_op_code, in2: cmd_data_in2, in1: cmd_data_in1};
    assign head   = fifo_mem_q[rd_ptr_q];

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    assign exec_illegal = (alu_op_q == ILLEGAL_OP);
`endif

    // FIFO storage, pointers and occupancy update
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = cmd_in;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, issue})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Next-state logic: IDLE waits for an issuable command, EXEC lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue) state_d = S_EXEC;
            S_EXEC: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand registers: load the FIFO head on issue, otherwise hold
    always_comb begin
        alu_in1_d = alu_in1_q;
        alu_in2_d = alu_in2_q;
        alu_op_d  = alu_op_q;
        if (issue) begin
            alu_in1_d = head.in1;
            alu_in2_d = head.in2;
            alu_op_d  = head.op;
        end
    end

    // Response register: capture at the end of EXEC, clear on handshake
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_slt_d   = rsp_slt_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        rsp_error_d = rsp_error_q;
`endif
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_data_out;
            rsp_carry_d = alu_carry_out;
            rsp_zero_d  = alu_zero_flag;
            rsp_slt_d   = alu_slt_flag;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            rsp_error_d = exec_illegal;
            if (exec_illegal) begin
                rsp_data_d  = '0;
                rsp_carry_d = 1'b0;
                rsp_zero_d  = 1'b1;
            end
`endif
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Control, operand and response registers with asynchronous reset
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_slt_q   <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            rsp_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_slt_q   <= rsp_slt_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            rsp_error_q <= rsp_error_d;
`endif
        end
    end

    // FIFO storage array
    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been written, and the pointers/count are reset.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready    = !fifo_full;
    assign cmd_level    = count_q;
    assign alu_data_in1 = alu_in1_q;
    assign alu_data_in2 = alu_in2_q;
    assign alu_op_code  = alu_op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_slt      = rsp_slt_q;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    assign alu_valid_data = (state_q == S_EXEC) && !exec_illegal;
    assign rsp_error      = rsp_error_q;
`else
    assign alu_valid_data = (state_q == S_EXEC);
    assign rsp_error      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer.
// A behavioural ALU closes the loop; expected responses are queued at
// command acceptance and a negedge monitor compares them in order.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic       err;
        logic       slt;
        logic       zero;
        logic       carry;
        logic [7:0] data;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data_in1;
    logic [7:0] cmd_data_in2;
    logic [2:0] cmd_op_code;
    logic [2:0] cmd_level;
    logic [7:0] alu_data_in1;
    logic [7:0] alu_data_in2;
    logic [2:0] alu_op_code;
    logic       alu_valid_data;
    logic [7:0] alu_data_out;
    logic       alu_carry_out;
    logic       alu_zero_flag;
    logic       alu_slt_flag;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_slt;
    logic       rsp_error;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_hs = -1;
    bit   spacing_en = 1'b0;
    int   illegal_pulses = 0;
    rsp_t exp_q[$];
    logic [8:0] alu_sum;

    alu_op_sequencer #(.WIDTH(8), .OPCODE(3), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data_in1   (cmd_data_in1),
        .cmd_data_in2   (cmd_data_in2),
        .cmd_op_code    (cmd_op_code),
        .cmd_level      (cmd_level),
        .alu_data_in1   (alu_data_in1),
        .alu_data_in2   (alu_data_in2),
        .alu_op_code    (alu_op_code),
        .alu_valid_data (alu_valid_data),
        .alu_data_out   (alu_data_out),
        .alu_carry_out  (alu_carry_out),
        .alu_zero_flag  (alu_zero_flag),
        .alu_slt_flag   (alu_slt_flag),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_carry      (rsp_carry),
        .rsp_zero       (rsp_zero),
        .rsp_slt        (rsp_slt),
        .rsp_error      (rsp_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Behavioural ALU: add, sub (carry = no borrow), and, or, xor; 101 gives a marker pattern
    always_comb begin
        alu_sum = 9'd0;
        case (alu_op_code)
            3'b000:  alu_sum = {1'b0, alu_data_in1} + {1'b0, alu_data_in2};
            3'b001:  alu_sum = {1'b0, alu_data_in1} + {1'b0, ~alu_data_in2} + 9'd1;
            3'b010:  alu_sum = {1'b0, alu_data_in1 & alu_data_in2};
            3'b011:  alu_sum = {1'b0, alu_data_in1 | alu_data_in2};
            3'b100:  alu_sum = {1'b0, alu_data_in1 ^ alu_data_in2};
            3'b101:  alu_sum = 9'h1A5;
            default: alu_sum = 9'd0;
        endcase
        alu_data_out  = alu_sum[7:0];
        alu_carry_out = alu_sum[8];
        alu_zero_flag = (alu_sum[7:0] == 8'h00);
        alu_slt_flag  = (alu_data_in1 > alu_data_in2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rsp_t mk(input logic [7:0] d, input logic c, input logic z,
                                input logic s, input logic e);
        rsp_t r;
        r.data  = d;
        r.carry = c;
        r.zero  = z;
        r.slt   = s;
        r.err   = e;
        return r;
    endfunction

    function automatic rsp_t dut_rsp();
        return mk(rsp_data, rsp_carry, rsp_zero, rsp_slt, rsp_error);
    endfunction

    // Response monitor: in-order compare on handshake, stability while stalled
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else if (rsp_ready) begin
                check("rsp", 32'(dut_rsp()), 32'(exp_q.pop_front()));
                if (spacing_en) begin
                    if (last_hs >= 0) check("rsp_spacing", 32'(cyc - last_hs), 32'd2);
                    last_hs = cyc;
                end
            end else begin
                check("rsp_stable", 32'(dut_rsp()), 32'(exp_q[0]));
            end
        end
    end

    // Count ALU strobes for the unimplemented opcode
    always @(negedge clk) begin
        if (!rst && alu_valid_data && alu_op_code == 3'b101) illegal_pulses = illegal_pulses + 1;
    end

    // Present one command, wait for acceptance, queue its expected response
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input rsp_t exp);
        int n;
        cmd_valid    = 1'b1;
        cmd_data_in1 = a;
        cmd_data_in2 = b;
        cmd_op_code  = op;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n = n + 1;
            if (n > 200) begin
                check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
                break;
            end
        end
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        rsp_t       exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_data_in1 = 8'h00;
        cmd_data_in2 = 8'h00;
        cmd_op_code  = 3'b000;
        rsp_ready    = 1'b1;

        // Hand-computed vectors: {a, b, op, {data, carry, zero, slt, err}}
        vecs[0] = '{8'h05, 8'h09, 3'b001, mk(8'hFC, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[1] = '{8'hF0, 8'h3C, 3'b010, mk(8'h30, 1'b0, 1'b0, 1'b1, 1'b0)};
        vecs[2] = '{8'h00, 8'h00, 3'b011, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b0)};
        vecs[3] = '{8'hAA, 8'h55, 3'b100, mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0)};
        vecs[4] = '{8'h80, 8'h7F, 3'b001, mk(8'h01, 1'b1, 1'b0, 1'b1, 1'b0)};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_level", 32'(cmd_level), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_valid", 32'(alu_valid_data), 32'd0);
        check("rst_alu_regs", 32'({alu_data_in1, alu_data_in2, alu_op_code}), 32'd0);
        check("rst_rsp_fields", 32'(dut_rsp()), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add with carry and issue/response latency
        send(8'h0F, 8'hF1, 3'b000, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        check("t0_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("t1_alu_valid", 32'(alu_valid_data), 32'd1);
        check("t1_alu_ops", 32'({alu_data_in1, alu_data_in2, alu_op_code}), 32'({8'h0F, 8'hF1, 3'b000}));
        check("t1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t2_alu_valid", 32'(alu_valid_data), 32'd0);
        wait_drain(20);

        // Subtract and logic ops, back to back
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
        wait_drain(40);

        // Full FIFO / backpressure: 1 in response slot + 4 buffered
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'h20 + 8'(i), 8'h01, 3'b000, mk(8'h21 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0));
        end
        check("full_cmd_level", 32'(cmd_level), 32'd4);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        cmd_valid    = 1'b1;
        cmd_data_in1 = 8'hEE;
        cmd_data_in2 = 8'hEE;
        cmd_op_code  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_refuse", 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("full_level_hold", 32'(cmd_level), 32'd4);
        last_hs    = -1;
        spacing_en = 1'b1;
        rsp_ready  = 1'b1;
        wait_drain(40);
        spacing_en = 1'b0;
        check("full_drained_level", 32'(cmd_level), 32'd0);

        // Simultaneous push and pop at level 2 over a 16-command wrap
        for (int i = 0; i < 3; i++) begin
            send(8'h10 + 8'(i), 8'(i), 3'b000, mk(8'h10 + 8'(2 * i), 1'b0, 1'b0, 1'b1, 1'b0));
        end
        check("pp_level_prime", 32'(cmd_level), 32'd2);
        for (int i = 3; i < 16; i++) begin
            send(8'h10 + 8'(i), 8'(i), 3'b000, mk(8'h10 + 8'(2 * i), 1'b0, 1'b0, 1'b1, 1'b0));
            check("pp_level_push", 32'(cmd_level), 32'd2);
            @(posedge clk);
            #1;
            check("pp_level_gap", 32'(cmd_level), 32'd2);
        end
        wait_drain(60);

        // Unimplemented opcode 101
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        send(8'h33, 8'h11, 3'b101, mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b1));
        wait_drain(20);
        check("illegal_alu_pulses", 32'(illegal_pulses), 32'd0);
`else
        send(8'h33, 8'h11, 3'b101, mk(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0));
        wait_drain(20);
        check("illegal_alu_pulses", 32'(illegal_pulses), 32'd1);
`endif

        // Reset during EXEC with 3 commands queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'h40 + 8'(i), 8'h02, 3'b000, mk(8'h42 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("pre_rst_alu_valid", 32'(alu_valid_data), 32'd1);
        check("pre_rst_level", 32'(cmd_level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_level", 32'(cmd_level), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_alu_valid", 32'(alu_valid_data), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_level", 32'(cmd_level), 32'd0);
        check("post_rst_alu_valid", 32'(alu_valid_data), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
